// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol constants and responder state encoding.
// The host-side reader uses the same package for its thresholds.
package dht11_pkg;

   localparam int T_RESP_LOW_US  = 80;
   localparam int T_RESP_HIGH_US = 80;
   localparam int T_BIT_LOW_US   = 50;
   localparam int T_BIT0_HIGH_US = 26;
   localparam int T_BIT1_HIGH_US = 70;
   localparam int T_END_LOW_US   = 50;
   localparam int FRAME_BITS     = 40;
   localparam int CNT_W          = 20;

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_START_LOW  = 4'd1;
   localparam logic [3:0] S_WAIT_REL   = 4'd2;
   localparam logic [3:0] S_RESP_DELAY = 4'd3;
   localparam logic [3:0] S_RESP_LOW   = 4'd4;
   localparam logic [3:0] S_RESP_HIGH  = 4'd5;
   localparam logic [3:0] S_BIT_LOW    = 4'd6;
   localparam logic [3:0] S_BIT_HIGH   = 4'd7;
   localparam logic [3:0] S_END_LOW    = 4'd8;

   function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c, input logic [7:0] d);
      return a + b + c + d;
   endfunction

endpackage

// File: rtl/dht11_us_timer.sv
// Microsecond time base: prescaler emitting o_us_tick every US_CYC cycles plus a µs counter.
// i_clr zeroes both so the next state starts counting from a clean microsecond boundary.
module dht11_us_timer #(
   parameter int US_CYC = 50,
   parameter int CNT_W  = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   output logic             o_us_tick,
   output logic [CNT_W-1:0] o_us_cnt
);

   localparam int PRE_W = (US_CYC > 1) ? $clog2(US_CYC) : 1;

   logic [PRE_W-1:0] r_pre;
   logic [CNT_W-1:0] r_cnt;
   logic             w_tick;

   assign w_tick    = (r_pre == PRE_W'(US_CYC - 1));
   assign o_us_tick = w_tick;
   assign o_us_cnt  = r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

endmodule

// File: rtl/dht11_responder.sv
// Device-side DHT11 model: accepts a host start pulse, sends presence response and 40-bit frame.
// Open-drain style: dht_oe=1 pulls the shared line low, otherwise the line is released.
module dht11_responder
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int START_MIN_US  = 10_000,
   parameter int RESP_DELAY_US = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dht_in,
   output logic       dht_oe,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_dec,
   output logic       busy,
   output logic       frame_done
);

   localparam int US_CYC = CLK_FREQ_HZ / 1_000_000;

   logic                  r_sync1;
   logic                  r_sync2;
   logic [1:0]            r_vld;
   logic                  r_prev;
   logic [3:0]            r_state;
   logic [FRAME_BITS-1:0] r_shift;
   logic [5:0]            r_bit;
   logic                  r_oe;
   logic                  r_busy;
   logic                  r_done;

   logic [3:0]            w_next;
   logic                  w_clr;
   logic                  w_us_tick;
   logic [CNT_W-1:0]      w_us_cnt;
   logic [CNT_W-1:0]      w_dur;
   logic                  w_elapsed;
   logic                  w_fall;
   logic                  w_last_bit;

   dht11_us_timer #(
      .US_CYC (US_CYC),
      .CNT_W  (CNT_W)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_clr),
      .o_us_tick (w_us_tick),
      .o_us_cnt  (w_us_cnt)
   );

   // r_vld marks when r_sync2 holds a real sample, so a line held low through reset
   // is never mistaken for a falling edge against the synchronizer's reset value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_vld   <= 2'b00;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= dht_in;
         r_sync2 <= r_sync1;
         r_vld   <= {r_vld[0], 1'b1};
         r_prev  <= r_vld[1] & r_sync2;
      end
   end

   assign w_fall     = r_vld[1] & r_prev & ~r_sync2;
   assign w_last_bit = (r_bit == 6'(FRAME_BITS - 1));

   always_comb begin
      w_dur = '0;
      case (r_state)
         S_START_LOW:  w_dur = CNT_W'(START_MIN_US);
         S_RESP_DELAY: w_dur = CNT_W'(RESP_DELAY_US);
         S_RESP_LOW:   w_dur = CNT_W'(T_RESP_LOW_US);
         S_RESP_HIGH:  w_dur = CNT_W'(T_RESP_HIGH_US);
         S_BIT_LOW:    w_dur = CNT_W'(T_BIT_LOW_US);
         S_BIT_HIGH:   w_dur = r_shift[FRAME_BITS-1] ? CNT_W'(T_BIT1_HIGH_US)
                                                     : CNT_W'(T_BIT0_HIGH_US);
         S_END_LOW:    w_dur = CNT_W'(T_END_LOW_US);
         default:      w_dur = '0;
      endcase
   end

   // Leaving on the tick that completes microsecond N-1 makes each state last exactly N*US_CYC.
   assign w_elapsed = w_us_tick && (w_us_cnt == w_dur - 1'b1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (w_fall) w_next = S_START_LOW;
         S_START_LOW:  if (r_sync2) w_next = S_IDLE;
                       else if (w_elapsed) w_next = S_WAIT_REL;
         S_WAIT_REL:   if (r_sync2) w_next = S_RESP_DELAY;
         S_RESP_DELAY: if (w_elapsed) w_next = S_RESP_LOW;
         S_RESP_LOW:   if (w_elapsed) w_next = S_RESP_HIGH;
         S_RESP_HIGH:  if (w_elapsed) w_next = S_BIT_LOW;
         S_BIT_LOW:    if (w_elapsed) w_next = S_BIT_HIGH;
         S_BIT_HIGH:   if (w_elapsed) w_next = w_last_bit ? S_END_LOW : S_BIT_LOW;
         S_END_LOW:    if (w_elapsed) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   assign w_clr = (w_next != r_state);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_oe    <= (w_next == S_RESP_LOW) || (w_next == S_BIT_LOW) || (w_next == S_END_LOW);
         r_busy  <= (w_next >= S_WAIT_REL) && (w_next <= S_END_LOW);
         r_done  <= (r_state == S_END_LOW) && (w_next == S_IDLE);
         if (r_state == S_START_LOW && w_next == S_WAIT_REL) begin
            r_shift <= {hum_int, hum_dec, temp_int, temp_dec,
                        dht11_checksum(hum_int, hum_dec, temp_int, temp_dec)};
            r_bit   <= '0;
         end else if (r_state == S_BIT_HIGH && w_next == S_BIT_LOW) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            r_bit   <= r_bit + 1'b1;
         end
      end
   end

   assign dht_oe     = r_oe;
   assign busy       = r_busy;
   assign frame_done = r_done;

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder at 1 MHz (1 cycle = 1 µs): decodes the line like a host.
module tb_dht11_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       host_low = 1'b0;
   logic       dht_in;
   logic       dht_oe;
   logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
   logic       busy;
   logic       frame_done;

   int n_cmp = 0;
   int n_bad = 0;
   int fd_cnt = 0;
   int busy_lo = 0;
   int to_cnt = 0;

   assign dht_in = ~(host_low | dht_oe);

   always #5 clk = ~clk;

   dht11_responder #(
      .CLK_FREQ_HZ   (1_000_000),
      .START_MIN_US  (1000),
      .RESP_DELAY_US (30)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .dht_in     (dht_in),
      .dht_oe     (dht_oe),
      .hum_int    (hum_int),
      .hum_dec    (hum_dec),
      .temp_int   (temp_int),
      .temp_dec   (temp_dec),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always @(negedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Length of the dht_oe==lvl phase that includes the current negedge sample.
   task automatic measure(input logic lvl, input int limit, output int len);
      len = 1;
      while (len < limit) begin
         @(negedge clk);
         if (dht_oe !== lvl) return;
         if (busy !== 1'b1) busy_lo++;
         len++;
      end
      to_cnt++;
   endtask

   // Called on the negedge at which the host releases the line.
   task automatic get_frame(output logic [39:0] data, output int dly, output int rl,
                            output int rh, output int el, output int badw);
      int l, h;
      logic b;
      data = '0;
      badw = 0;
      measure(1'b0, 200, dly);
      measure(1'b1, 200, rl);
      measure(1'b0, 200, rh);
      for (int i = 0; i < 40; i++) begin
         measure(1'b1, 200, l);
         if (l < 49 || l > 51) badw++;
         measure(1'b0, 200, h);
         b = (h > 48);
         if (b ? (h < 69 || h > 71) : (h < 25 || h > 27)) badw++;
         data = {data[38:0], b};
      end
      measure(1'b1, 200, el);
   endtask

   task automatic host_start(input int us);
      @(negedge clk);
      host_low = 1'b1;
      repeat (us) @(negedge clk);
      host_low = 1'b0;
   endtask

   task automatic wait_rises(input int n, output int got);
      logic prev;
      got = 0;
      prev = dht_oe;
      for (int c = 0; c < 8000 && got < n; c++) begin
         @(negedge clk);
         if (dht_oe === 1'b1 && prev !== 1'b1) got++;
         prev = dht_oe;
      end
   endtask

   task automatic check_data(input string name, input logic [39:0] act, input logic [39:0] exp);
      for (int k = 4; k >= 0; k--) begin
         n_cmp++;
         if (act[k*8 +: 8] !== exp[k*8 +: 8]) begin
            n_bad++;
            $display("FAIL %s byte%0d: got %02h expected %02h", name, 4 - k, act[k*8 +: 8], exp[k*8 +: 8]);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (dht_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b expected 0", dht_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", frame_done); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_low_at_reset;
      int hits = 0;
      rst_n = 1'b0;
      host_low = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (1500) begin @(negedge clk); if (busy === 1'b1 || dht_oe === 1'b1) hits++; end
      host_low = 1'b0;
      repeat (300) begin @(negedge clk); if (busy === 1'b1 || dht_oe === 1'b1) hits++; end
      n_cmp++; if (hits != 0) begin n_bad++; $display("FAIL low_at_reset: active cycles %0d expected 0", hits); end
   endtask

   task automatic test_nominal;
      logic [39:0] d;
      int dly, rl, rh, el, badw, fd0;
      hum_int = 8'h3C; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
      fd0 = fd_cnt; busy_lo = 0; to_cnt = 0;
      @(negedge clk);
      host_low = 1'b1;
      repeat (1500) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_at_accept: got %b expected 1", busy); end
      host_low = 1'b0;
      get_frame(d, dly, rl, rh, el, badw);
      repeat (5) @(negedge clk);
      n_cmp++; if (dly < 30 || dly > 34) begin n_bad++; $display("FAIL resp_delay: got %0d expected 30..34", dly); end
      n_cmp++; if (rl < 79 || rl > 81) begin n_bad++; $display("FAIL resp_low: got %0d expected 80", rl); end
      n_cmp++; if (rh < 79 || rh > 81) begin n_bad++; $display("FAIL resp_high: got %0d expected 80", rh); end
      n_cmp++; if (el < 49 || el > 51) begin n_bad++; $display("FAIL end_low: got %0d expected 50", el); end
      check_data("nominal", d, 40'h3C_00_19_00_55);
      n_cmp++; if (badw != 0) begin n_bad++; $display("FAIL nominal_widths: bad %0d expected 0", badw); end
      n_cmp++; if (busy_lo != 0) begin n_bad++; $display("FAIL busy_hold: low cycles %0d expected 0", busy_lo); end
      n_cmp++; if (fd_cnt - fd0 != 1) begin n_bad++; $display("FAIL done_pulses: got %0d expected 1", fd_cnt - fd0); end
      n_cmp++; if (to_cnt != 0) begin n_bad++; $display("FAIL nominal_timeout: got %0d expected 0", to_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_short_pulse;
      int hits = 0;
      @(negedge clk);
      host_low = 1'b1;
      repeat (500) begin @(negedge clk); if (busy === 1'b1 || dht_oe === 1'b1) hits++; end
      host_low = 1'b0;
      repeat (300) begin @(negedge clk); if (busy === 1'b1 || dht_oe === 1'b1) hits++; end
      n_cmp++; if (hits != 0) begin n_bad++; $display("FAIL short_pulse: active cycles %0d expected 0", hits); end
   endtask

   task automatic test_checksum_wrap;
      logic [39:0] d;
      int dly, rl, rh, el, badw;
      hum_int = 8'hFF; hum_dec = 8'hFF; temp_int = 8'h01; temp_dec = 8'h02;
      to_cnt = 0;
      host_start(1500);
      get_frame(d, dly, rl, rh, el, badw);
      check_data("wrap", d, 40'hFF_FF_01_02_01);
      n_cmp++; if (to_cnt != 0 || badw != 0) begin n_bad++; $display("FAIL wrap_timing: to %0d bad %0d expected 0/0", to_cnt, badw); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_midframe_change;
      logic [39:0] d;
      int dly, rl, rh, el, badw, got;
      hum_int = 8'h3C; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
      to_cnt = 0;
      fork
         begin host_start(1500); get_frame(d, dly, rl, rh, el, badw); end
         begin wait_rises(12, got); temp_int = 8'h20; end
      join
      n_cmp++; if (got != 12) begin n_bad++; $display("FAIL mid_bit10_reach: got %0d expected 12", got); end
      check_data("midchange", d, 40'h3C_00_19_00_55);
      temp_int = 8'h19;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_midframe;
      logic [39:0] d;
      int dly, rl, rh, el, badw, got;
      to_cnt = 0;
      host_start(1500);
      wait_rises(22, got);
      repeat (10) @(negedge clk);
      n_cmp++; if (dht_oe !== 1'b1) begin n_bad++; $display("FAIL abort_pre_oe: got %b expected 1", dht_oe); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (dht_oe !== 1'b0) begin n_bad++; $display("FAIL abort_oe: got %b expected 0", dht_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      host_start(1500);
      get_frame(d, dly, rl, rh, el, badw);
      check_data("after_abort", d, 40'h3C_00_19_00_55);
      n_cmp++; if (to_cnt != 0 || badw != 0) begin n_bad++; $display("FAIL after_abort_timing: to %0d bad %0d expected 0/0", to_cnt, badw); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [39:0] d1, d2;
      int dly, rl, rh, el, b1, b2, fd0;
      fd0 = fd_cnt; to_cnt = 0;
      host_start(1500);
      get_frame(d1, dly, rl, rh, el, b1);
      repeat (9) @(negedge clk);
      host_start(1500);
      get_frame(d2, dly, rl, rh, el, b2);
      repeat (5) @(negedge clk);
      check_data("b2b_first", d1, 40'h3C_00_19_00_55);
      check_data("b2b_second", d2, 40'h3C_00_19_00_55);
      n_cmp++; if (b1 + b2 != 0) begin n_bad++; $display("FAIL b2b_widths: bad %0d expected 0", b1 + b2); end
      n_cmp++; if (fd_cnt - fd0 != 2) begin n_bad++; $display("FAIL b2b_done: got %0d expected 2", fd_cnt - fd0); end
      n_cmp++; if (to_cnt != 0) begin n_bad++; $display("FAIL b2b_timeout: got %0d expected 0", to_cnt); end
   endtask

   initial begin
      test_reset();
      test_low_at_reset();
      test_nominal();
      test_short_pulse();
      test_checksum_wrap();
      test_midframe_change();
      test_reset_midframe();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
